// File: rtl/pwm_in_snapshot_arbiter.sv
// Shares PWM-input result registers between a host requester and a round-robin
// auto-scan timer, returning a double-sampled, classified 64-bit snapshot per grant.
module pwm_in_snapshot_arbiter #(
   parameter int NCH       = 4,
   parameter int SCAN_DIV  = 75000,
   parameter int MAX_RETRY = 3,
   localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              xclk,
   input  logic              reset,
   input  logic [NCH*32-1:0] ch_period,
   input  logic [NCH*32-1:0] ch_ontime,
   input  logic              host_req,
   input  logic [CW-1:0]     host_ch,
   output logic              host_ack,
   input  logic              scan_en,
   output logic              scan_overrun,
   output logic              busy,
   output logic              res_stb,
   output logic              res_src,
   output logic [CW-1:0]     res_ch,
   output logic [31:0]       res_period,
   output logic [31:0]       res_ontime,
   output logic [1:0]        res_status
);

   localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [2:0] {IDLE, SEL, CAP0, CMP, OUT} state_t;

   state_t          state_reg, state_next;
   logic            src_reg;
   logic [CW-1:0]   ch_reg;
   logic [RW-1:0]   retry_reg;
   logic [31:0]     tmp_period_reg, tmp_ontime_reg;
   logic [31:0]     live_period_reg, live_ontime_reg;
   logic            torn_reg;
   logic [TW-1:0]   timer_reg;
   logic            scan_pending_reg;
   logic [CW-1:0]   scan_idx_reg;

   logic            grant_host, grant_scan;
   logic            snap_match, retry_exhausted;
   logic            scan_tick, scan_done;
   logic [31:0]     mux_period, mux_ontime;
   logic [31:0]     period_arr [NCH];
   logic [31:0]     ontime_arr [NCH];

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_unpack
         assign period_arr[gi] = ch_period[32*gi +: 32];
         assign ontime_arr[gi] = ch_ontime[32*gi +: 32];
      end
   endgenerate

   assign mux_period      = period_arr[ch_reg];
   assign mux_ontime      = ontime_arr[ch_reg];
   assign snap_match      = (mux_period == tmp_period_reg) && (mux_ontime == tmp_ontime_reg);
   assign retry_exhausted = (retry_reg == RW'(MAX_RETRY));
   assign busy            = (state_reg != IDLE);
   assign scan_tick       = scan_en && (timer_reg == TW'(SCAN_DIV - 1));
   assign scan_done       = (state_reg == OUT) && src_reg;

   always_ff @(posedge xclk or negedge reset) begin
      if (!reset) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Host has fixed priority; a pending scan is only honoured while scanning is enabled.
   always_comb begin
      state_next = state_reg;
      grant_host = 1'b0;
      grant_scan = 1'b0;
      case (state_reg)
         IDLE: begin
            if (host_req) begin
               grant_host = 1'b1;
               state_next = SEL;
            end else if (scan_pending_reg && scan_en) begin
               grant_scan = 1'b1;
               state_next = SEL;
            end
         end
         SEL:  state_next = CAP0;
         CAP0: state_next = CMP;
         CMP:  state_next = (snap_match || retry_exhausted) ? OUT : CAP0;
         OUT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge xclk or negedge reset) begin
      if (!reset) begin
         src_reg         <= 1'b0;
         ch_reg          <= '0;
         retry_reg       <= '0;
         tmp_period_reg  <= '0;
         tmp_ontime_reg  <= '0;
         live_period_reg <= '0;
         live_ontime_reg <= '0;
         torn_reg        <= 1'b0;
         host_ack        <= 1'b0;
         res_stb         <= 1'b0;
         res_src         <= 1'b0;
         res_ch          <= '0;
         res_period      <= '0;
         res_ontime      <= '0;
         res_status      <= 2'b00;
      end else begin
         host_ack <= 1'b0;
         res_stb  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (grant_host || grant_scan) begin
                  src_reg   <= grant_scan;
                  ch_reg    <= grant_scan ? scan_idx_reg : host_ch;
                  retry_reg <= '0;
               end
            end
            CAP0: begin
               tmp_period_reg <= mux_period;
               tmp_ontime_reg <= mux_ontime;
            end
            CMP: begin
               // The result always reports what was live in the final compare cycle.
               live_period_reg <= mux_period;
               live_ontime_reg <= mux_ontime;
               torn_reg        <= !snap_match;
               if (!snap_match && !retry_exhausted) retry_reg <= retry_reg + RW'(1);
            end
            OUT: begin
               res_stb    <= 1'b1;
               host_ack   <= !src_reg;
               res_src    <= src_reg;
               res_ch     <= ch_reg;
               res_period <= live_period_reg;
               res_ontime <= live_ontime_reg;
               if (torn_reg)                               res_status <= 2'b10;
               else if (live_period_reg == '0)             res_status <= 2'b01;
               else if (live_ontime_reg > live_period_reg) res_status <= 2'b11;
               else                                        res_status <= 2'b00;
            end
            default: ;
         endcase
      end
   end

   // A tick that lands while the previous scan is still pending keeps it pending.
   always_ff @(posedge xclk or negedge reset) begin
      if (!reset) begin
         timer_reg        <= '0;
         scan_pending_reg <= 1'b0;
         scan_overrun     <= 1'b0;
         scan_idx_reg     <= '0;
      end else begin
         if (!scan_en) begin
            timer_reg        <= '0;
            scan_pending_reg <= 1'b0;
            scan_overrun     <= 1'b0;
         end else if (scan_tick) begin
            timer_reg        <= '0;
            scan_pending_reg <= 1'b1;
            if (scan_pending_reg) scan_overrun <= 1'b1;
         end else begin
            timer_reg <= timer_reg + TW'(1);
            if (scan_done) scan_pending_reg <= 1'b0;
         end
         if (scan_done)
            scan_idx_reg <= (scan_idx_reg == CW'(NCH - 1)) ? '0 : scan_idx_reg + CW'(1);
      end
   end

endmodule

// File: tb/tb_pwm_in_snapshot_arbiter.sv
// Scoreboard bench for pwm_in_snapshot_arbiter: stimulus queues expected results,
// a negedge monitor pops and compares one entry per res_stb.
module tb_pwm_in_snapshot_arbiter;
   localparam int NCH = 4;
   localparam logic [31:0] TOG = 32'h0000_0101;

   logic              xclk, reset;
   logic [NCH*32-1:0] ch_period, ch_ontime;
   logic              host_req, host_ack, scan_en, scan_overrun, busy;
   logic [1:0]        host_ch, res_ch, res_status;
   logic              res_stb, res_src;
   logic [31:0]       res_period, res_ontime;

   typedef struct {
      logic src; logic [1:0] ch; logic [31:0] per; logic [31:0] ont; logic [1:0] st; int cyc;
   } exp_t;

   exp_t        sbq[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic [31:0] per_a [NCH];
   logic [31:0] ont_a [NCH];

   pwm_in_snapshot_arbiter #(.NCH(NCH), .SCAN_DIV(8), .MAX_RETRY(3)) dut (
      .xclk(xclk), .reset(reset), .ch_period(ch_period), .ch_ontime(ch_ontime),
      .host_req(host_req), .host_ch(host_ch), .host_ack(host_ack),
      .scan_en(scan_en), .scan_overrun(scan_overrun), .busy(busy),
      .res_stb(res_stb), .res_src(res_src), .res_ch(res_ch),
      .res_period(res_period), .res_ontime(res_ontime), .res_status(res_status)
   );

   initial begin
      xclk = 1'b0;
      forever #5 xclk = ~xclk;
   end

   always @(posedge xclk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   always @(negedge xclk) begin
      exp_t e;
      if (res_stb) begin
         $display("txn src=%0d ch=%0d period=%h ontime=%h status=%b cycle=%0d",
                  res_src, res_ch, res_period, res_ontime, res_status, cyc);
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stray_stb: res_stb=1 ch=%0d at cycle %0d, required no strobe", res_ch, cyc);
         end else begin
            e = sbq.pop_front();
            chk("res_src", 64'(res_src), 64'(e.src));
            chk("res_ch", 64'(res_ch), 64'(e.ch));
            chk("res_period", 64'(res_period), 64'(e.per));
            chk("res_ontime", 64'(res_ontime), 64'(e.ont));
            chk("res_status", 64'(res_status), 64'(e.st));
            chk("host_ack", 64'(host_ack), 64'(!e.src));
            if (e.cyc >= 0) chk("stb_cycle", 64'(cyc), 64'(e.cyc));
         end
      end else if (host_ack) begin
         checks++;
         errors++;
         $display("FAIL ack_no_stb: host_ack=1 res_stb=0 at cycle %0d, required host_ack=0", cyc);
      end
   end

   task automatic apply_ch();
      for (int i = 0; i < NCH; i++) begin
         ch_period[32*i +: 32] = per_a[i];
         ch_ontime[32*i +: 32] = ont_a[i];
      end
   endtask

   task automatic push(input logic src, input int ch, input logic [31:0] per,
                       input logic [1:0] st, input int c);
      exp_t e;
      e.src = src; e.ch = 2'(ch); e.per = per; e.ont = ont_a[ch]; e.st = st; e.cyc = c;
      sbq.push_back(e);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge xclk);
   endtask

   task automatic drain(input int budget);
      int t = 0;
      while (sbq.size() != 0 && t < budget) begin
         @(negedge xclk);
         t++;
      end
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", sbq.size());
         sbq.delete();
      end
   endtask

   // Host request; ch period is XOR-toggled after each of the first ntog clock edges.
   task automatic host_txn(input int ch, input logic [1:0] st, input int lat,
                           input int ntog, input logic [31:0] xper);
      int k;
      bit got;
      @(negedge xclk);
      host_ch  = 2'(ch);
      host_req = 1'b1;
      k = cyc + 1;
      push(1'b0, ch, xper, st, k + lat);
      got = 1'b0;
      for (int t = 0; t < 30 && !got; t++) begin
         @(negedge xclk);
         if (host_ack) begin
            host_req = 1'b0;
            got = 1'b1;
         end else if (t < ntog) begin
            per_a[ch] ^= TOG;
            apply_ch();
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL host_ack_timeout: ch=%0d no host_ack in 30 cycles, required ack", ch);
         host_req = 1'b0;
      end
   endtask

   initial begin
      int k, c0, n;
      bit got;
      reset = 1'b0; host_req = 1'b0; host_ch = 2'd0; scan_en = 1'b0;
      per_a = '{32'h0000_1000, 32'h0000_2000, 32'h0124_F800, 32'h0003_0000};
      ont_a = '{32'h0000_0800, 32'h0000_0400, 32'h0092_7C00, 32'h0001_0000};
      apply_ch();
      repeat (3) @(negedge xclk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_stb", 64'(res_stb), 64'd0);
      chk("rst_ack", 64'(host_ack), 64'd0);
      chk("rst_overrun", 64'(scan_overrun), 64'd0);
      chk("rst_res", {res_period, res_ontime}, 64'd0);
      chk("rst_misc", 64'({res_src, res_ch, res_status}), 64'd0);
      reset = 1'b1;

      host_txn(2, 2'b00, 4, 0, 32'h0124_F800);
      drain(10);

      // Reset asserted for one cycle while in CMP
      @(negedge xclk);
      host_ch = 2'd3; host_req = 1'b1; k = cyc + 1;
      wait_until(k + 2);
      reset = 1'b0;
      @(negedge xclk);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_stb", 64'(res_stb), 64'd0);
      chk("midrst_res", {res_period, res_ontime}, 64'd0);
      chk("midrst_misc", 64'({res_src, res_ch, res_status, host_ack}), 64'd0);
      host_req = 1'b0;
      reset = 1'b1;
      repeat (10) @(negedge xclk);

      // Round-robin scan, first tick 8 edges after enable, result 5 edges later
      @(negedge xclk);
      scan_en = 1'b1; c0 = cyc;
      for (int i = 0; i < 5; i++) push(1'b1, i % 4, per_a[i % 4], 2'b00, c0 + 13 + 8 * i);
      drain(80);
      chk("scan_overrun_rr", 64'(scan_overrun), 64'd0);
      scan_en = 1'b0;

      // Host granted on the same edge that the scan tick sets pending
      @(negedge xclk);
      scan_en = 1'b1; c0 = cyc;
      wait_until(c0 + 7);
      host_ch = 2'd0; host_req = 1'b1;
      push(1'b0, 0, per_a[0], 2'b00, c0 + 12);
      push(1'b1, 1, per_a[1], 2'b00, c0 + 17);
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge xclk);
         if (host_ack) begin host_req = 1'b0; got = 1'b1; end
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL collide_ack_timeout: no host_ack, required ack");
         host_req = 1'b0;
      end
      wait_until(c0 + 14);
      scan_en = 1'b0;
      drain(20);
      chk("scan_overrun_collide", 64'(scan_overrun), 64'd0);

      host_txn(1, 2'b10, 10, 12, 32'h0000_2000 ^ TOG);
      per_a[1] = 32'h0000_2000; apply_ch();
      host_txn(1, 2'b00, 6, 3, 32'h0000_2000 ^ TOG);
      per_a[1] = 32'h0000_2000; apply_ch();

      per_a[0] = 32'd0; apply_ch();
      host_txn(0, 2'b01, 4, 0, 32'd0);
      per_a[0] = 32'h0000_1000;
      per_a[3] = 32'd50; ont_a[3] = 32'd100; apply_ch();
      host_txn(3, 2'b11, 4, 0, 32'd50);
      per_a[3] = 32'h0003_0000; ont_a[3] = 32'h0001_0000; apply_ch();
      drain(10);

      // Back-to-back host requests starve the scan until the second tick overruns
      @(negedge xclk);
      scan_en = 1'b1; host_ch = 2'd2; host_req = 1'b1; k = cyc + 1;
      for (int i = 0; i < 5; i++) push(1'b0, 2, per_a[2], 2'b00, k + 4 + 5 * i);
      n = 0;
      for (int t = 0; t < 60 && n < 5; t++) begin
         @(negedge xclk);
         if (host_ack) begin
            n++;
            if (n == 3) chk("overrun_before_2nd_tick", 64'(scan_overrun), 64'd0);
            if (n == 5) begin
               chk("overrun_set", 64'(scan_overrun), 64'd1);
               host_req = 1'b0;
               scan_en = 1'b0;
            end
         end
      end
      if (n < 5) begin
         checks++; errors++;
         $display("FAIL overrun_ack_timeout: got %0d acks, required 5", n);
      end
      host_req = 1'b0;
      scan_en = 1'b0;
      @(negedge xclk);
      chk("overrun_clear", 64'(scan_overrun), 64'd0);
      drain(10);
      repeat (20) @(negedge xclk);
      chk("final_busy", 64'(busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
